// File: rtl/led_nios2_debug_cmd_arbiter.sv
// Round-robin arbiter sharing the Nios II OCI debug memory port between the JTAG
// command path and a local requester; one transaction in flight, with a WAIT timeout.
module led_nios2_debug_cmd_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              j_req,
    input  logic              j_write,
    input  logic [ADDR_W-1:0] j_addr,
    input  logic [DATA_W-1:0] j_wdata,
    output logic              j_ack,
    output logic [DATA_W-1:0] j_rdata,
    output logic              j_err,

    input  logic              l_req,
    input  logic              l_write,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_err,

    output logic              oci_req,
    output logic              oci_write,
    output logic [ADDR_W-1:0] oci_addr,
    output logic [DATA_W-1:0] oci_wdata,
    input  logic              oci_ready,
    input  logic [DATA_W-1:0] oci_rdata,
    input  logic              oci_error,

    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_owner;
    logic               r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_oci_write;
    logic [ADDR_W-1:0]  r_oci_addr;
    logic [DATA_W-1:0]  r_oci_wdata;
    logic [DATA_W-1:0]  r_j_rdata;
    logic [DATA_W-1:0]  r_l_rdata;
    logic               r_j_err;
    logic               r_l_err;
    logic               w_any_req;
    logic               w_grant_l;
    logic               w_timeout;

    // Local wins when it is the only requester, or both request and the pointer favours it.
    assign w_any_req = j_req | l_req;
    assign w_grant_l = l_req & (~j_req | r_ptr);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (oci_ready || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_ptr       <= 1'b0;
            r_cnt       <= '0;
            r_oci_write <= 1'b0;
            r_oci_addr  <= '0;
            r_oci_wdata <= '0;
            r_j_rdata   <= '0;
            r_l_rdata   <= '0;
            r_j_err     <= 1'b0;
            r_l_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_grant_l;
                        r_oci_write <= w_grant_l ? l_write : j_write;
                        r_oci_addr  <= w_grant_l ? l_addr  : j_addr;
                        r_oci_wdata <= w_grant_l ? l_wdata : j_wdata;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    // A ready on the last counted cycle completes normally rather than timing out.
                    if (oci_ready) begin
                        if (r_owner) begin
                            r_l_rdata <= oci_rdata;
                            r_l_err   <= oci_error;
                        end else begin
                            r_j_rdata <= oci_rdata;
                            r_j_err   <= oci_error;
                        end
                    end else if (w_timeout) begin
                        if (r_owner) begin
                            r_l_rdata <= '0;
                            r_l_err   <= 1'b1;
                        end else begin
                            r_j_rdata <= '0;
                            r_j_err   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: r_ptr <= ~r_owner;
                default: ;
            endcase
        end
    end

    assign oci_req   = (r_state == S_ISSUE);
    assign oci_write = r_oci_write;
    assign oci_addr  = r_oci_addr;
    assign oci_wdata = r_oci_wdata;
    assign j_ack     = (r_state == S_DONE) & ~r_owner;
    assign l_ack     = (r_state == S_DONE) &  r_owner;
    assign j_rdata   = r_j_rdata;
    assign l_rdata   = r_l_rdata;
    assign j_err     = r_j_err;
    assign l_err     = r_l_err;
    assign busy      = (r_state != S_IDLE);
    assign owner     = r_owner;

endmodule

// File: tb/tb_led_nios2_debug_cmd_arbiter.sv
// Directed bench for led_nios2_debug_cmd_arbiter: cycle-accurate vectors against a small
// OCI responder whose latency and data are set per test.
module tb_led_nios2_debug_cmd_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int TO     = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              j_req = 1'b0, j_write = 1'b0;
    logic [ADDR_W-1:0] j_addr = '0;
    logic [DATA_W-1:0] j_wdata = '0;
    logic              l_req = 1'b0, l_write = 1'b0;
    logic [ADDR_W-1:0] l_addr = '0;
    logic [DATA_W-1:0] l_wdata = '0;
    logic              j_ack, l_ack, j_err, l_err;
    logic [DATA_W-1:0] j_rdata, l_rdata;
    logic              oci_req, oci_write;
    logic [ADDR_W-1:0] oci_addr;
    logic [DATA_W-1:0] oci_wdata;
    logic              oci_ready;
    logic [DATA_W-1:0] oci_rdata;
    logic              oci_error;
    logic              busy, owner;

    // Responder configuration, written only by the main sequence.
    bit                rsp_en = 1'b0;
    int                rsp_delay = 0;
    logic [DATA_W-1:0] rsp_data = '0;
    logic              rsp_err = 1'b0;
    bit                spur_issue = 1'b0;
    int                spur_idle_req = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_oci    = 0;
    int cyc;

    led_nios2_debug_cmd_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .j_req    (j_req),
        .j_write  (j_write),
        .j_addr   (j_addr),
        .j_wdata  (j_wdata),
        .j_ack    (j_ack),
        .j_rdata  (j_rdata),
        .j_err    (j_err),
        .l_req    (l_req),
        .l_write  (l_write),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_ack    (l_ack),
        .l_rdata  (l_rdata),
        .l_err    (l_err),
        .oci_req  (oci_req),
        .oci_write(oci_write),
        .oci_addr (oci_addr),
        .oci_wdata(oci_wdata),
        .oci_ready(oci_ready),
        .oci_rdata(oci_rdata),
        .oci_error(oci_error),
        .busy     (busy),
        .owner    (owner)
    );

    initial forever #5 clk = ~clk;

    // OCI responder: drives just after each rising edge, one-cycle ready pulses.
    initial begin
        int  spur_idle_done = 0;
        bit  pending = 1'b0;
        int  pend_wait = 0;
        oci_ready = 1'b0;
        oci_rdata = '0;
        oci_error = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            oci_ready = 1'b0;
            oci_rdata = '0;
            oci_error = 1'b0;
            if (spur_idle_req > spur_idle_done) begin
                spur_idle_done++;
                oci_ready = 1'b1;
                oci_rdata = 32'hBAD0_BAD0;
                oci_error = 1'b1;
            end
            if (pending) begin
                if (pend_wait == 0) begin
                    pending   = 1'b0;
                    oci_ready = 1'b1;
                    oci_rdata = rsp_data;
                    oci_error = rsp_err;
                end else begin
                    pend_wait--;
                end
            end
            if (oci_req && rsp_en) begin
                pending   = 1'b1;
                pend_wait = rsp_delay;
                if (spur_issue) begin
                    oci_ready = 1'b1;
                    oci_rdata = 32'hBAD1_BAD1;
                    oci_error = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required done earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Returns the number of falling edges until an ack is seen, or -1 if none within limit.
    task automatic run_until_ack(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (oci_req) n_oci++;
            if (j_ack || l_ack) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {56'd0, busy, owner, j_ack, l_ack, oci_req, oci_write, j_err, l_err}, 64'd0);
        check({tag, "_addr"},  {56'd0, oci_addr}, 64'd0);
        check({tag, "_wdata"}, {32'd0, oci_wdata}, 64'd0);
        check({tag, "_jrdata"}, {32'd0, j_rdata}, 64'd0);
        check({tag, "_lrdata"}, {32'd0, l_rdata}, 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        j_req = 1'b0;
        l_req = 1'b0;
        tick();
        tick();
        check_all_zero(tag);
        reset = 1'b0;
    endtask

    initial begin
        bit saw_ack;
        bit saw_busy;

        // Basic read: oci_req at cycle 1, ready at 2, ack at 3.
        do_reset("rst0");
        rsp_en = 1'b1; rsp_delay = 0; rsp_data = 32'hDEAD_BEEF; rsp_err = 1'b0;
        j_req = 1'b1; j_write = 1'b0; j_addr = 8'h10; j_wdata = 32'h0;
        tick();
        check("rd_c1_ctrl", {busy, owner, oci_req, oci_write, j_ack}, 5'b10100);
        check("rd_c1_addr", oci_addr, 8'h10);
        tick();
        check("rd_c2_ctrl", {busy, oci_req, j_ack}, 3'b100);
        tick();
        check("rd_c3_ack", {j_ack, l_ack}, 2'b10);
        check("rd_c3_rdata", j_rdata, 32'hDEAD_BEEF);
        check("rd_c3_err", j_err, 1'b0);
        check("rd_c3_l_untouched", {l_err, l_rdata}, 33'd0);
        check("rd_c3_addr_stable", oci_addr, 8'h10);
        j_req = 1'b0;
        tick();
        check("rd_c4_idle", {busy, j_ack}, 2'b00);

        // Both requesting continuously: strict J, L, J, L alternation.
        do_reset("rst1");
        rsp_data = 32'h1357_9BDF;
        j_req = 1'b1; j_write = 1'b0; j_addr = 8'h30;
        l_req = 1'b1; l_write = 1'b1; l_addr = 8'h20; l_wdata = 32'hA5A5_A5A5;
        for (int t = 0; t < 4; t++) begin
            logic exp_l;
            exp_l = t[0];
            run_until_ack(12, cyc);
            check($sformatf("rr%0d_latency", t), cyc, 3);
            check($sformatf("rr%0d_owner", t), owner, exp_l);
            check($sformatf("rr%0d_acks", t), {j_ack, l_ack}, {~exp_l, exp_l});
            check($sformatf("rr%0d_addr", t), oci_addr, exp_l ? 8'h20 : 8'h30);
            check($sformatf("rr%0d_write", t), oci_write, exp_l);
            tick();
            check($sformatf("rr%0d_ack_1cyc", t), {j_ack, l_ack, busy}, 3'b000);
        end
        check("rr_j_rdata", j_rdata, 32'h1357_9BDF);
        check("rr_l_rdata", l_rdata, 32'h1357_9BDF);
        j_req = 1'b0;
        l_req = 1'b0;
        tick();

        // Local write, OCI never answers: error ack at TIMEOUT+2.
        rsp_en = 1'b0;
        n_oci = 0;
        l_req = 1'b1; l_write = 1'b1; l_addr = 8'hFF; l_wdata = 32'h1234_5678;
        run_until_ack(40, cyc);
        check("to_latency", cyc, TO + 2);
        check("to_oci_req_count", n_oci, 1);
        check("to_acks", {j_ack, l_ack}, 2'b01);
        check("to_l_err", l_err, 1'b1);
        check("to_l_rdata", l_rdata, 32'h0);
        check("to_oci_cmd", {oci_write, oci_addr, oci_wdata}, {1'b1, 8'hFF, 32'h1234_5678});
        check("to_j_untouched", {j_err, j_rdata}, {1'b0, 32'h1357_9BDF});
        l_req = 1'b0;
        tick();
        check("to_busy_after", {busy, l_ack, l_err}, 3'b001);

        // Ready with error on the last counted WAIT cycle: normal completion wins.
        rsp_en = 1'b1; rsp_delay = TO - 1; rsp_data = 32'hCAFE_F00D; rsp_err = 1'b1;
        j_req = 1'b1; j_write = 1'b0; j_addr = 8'h44;
        run_until_ack(40, cyc);
        check("edge_latency", cyc, TO + 2);
        check("edge_acks", {j_ack, l_ack, owner}, 3'b100);
        check("edge_j_rdata", j_rdata, 32'hCAFE_F00D);
        check("edge_j_err", j_err, 1'b1);
        check("edge_l_untouched", {l_err, l_rdata}, {1'b1, 32'h0});
        j_req = 1'b0;
        tick();

        // Reset asserted in WAIT; a late ready must be ignored afterwards.
        rsp_delay = 3; rsp_data = 32'h7777_8888; rsp_err = 1'b0;
        j_req = 1'b1; j_addr = 8'h55;
        tick();
        tick();
        check("rstw_in_wait", {busy, oci_req}, 2'b10);
        reset = 1'b1;
        tick();
        check_all_zero("rstw");
        reset = 1'b0;
        j_req = 1'b0;
        saw_ack = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (j_ack || l_ack) saw_ack = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        check("rstw_no_ack", saw_ack, 1'b0);
        check("rstw_no_busy", saw_busy, 1'b0);
        check("rstw_late_ready_ignored", {j_err, j_rdata}, 33'd0);

        // Spurious ready while idle.
        spur_idle_req++;
        tick();
        tick();
        check("spur_idle", {busy, j_ack, l_ack, j_err, l_err}, 5'b00000);
        check("spur_idle_rdata", j_rdata, 32'h0);

        // Spurious ready during ISSUE, then real data two WAIT cycles later.
        spur_issue = 1'b1; rsp_delay = 1; rsp_data = 32'h600D_F00D; rsp_err = 1'b0;
        j_req = 1'b1; j_write = 1'b0; j_addr = 8'h66;
        run_until_ack(12, cyc);
        check("spur_issue_latency", cyc, 4);
        check("spur_issue_rdata", j_rdata, 32'h600D_F00D);
        check("spur_issue_err", j_err, 1'b0);

        // Request held through the following IDLE is a fresh transaction.
        spur_issue = 1'b0; rsp_delay = 0; rsp_data = 32'h1111_2222;
        tick();
        check("held_idle", {busy, j_ack, oci_req}, 3'b000);
        tick();
        check("held_reissue", {busy, oci_req, owner}, 3'b110);
        check("held_addr", oci_addr, 8'h66);
        run_until_ack(12, cyc);
        check("held_latency", cyc, 2);
        check("held_rdata", j_rdata, 32'h1111_2222);
        j_req = 1'b0;
        tick();
        check("held_done", {busy, j_ack}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
